// File: rtl/lose_overlay_compositor.sv
// Composites the "game lost" overlay over the background pixel stream and animates its slide-in.
// Optional colour keying of KEY_RGB is compiled in with LOSE_OVERLAY_KEY_EN.
module lose_overlay_compositor #(
  parameter int IMG_W      = 390,
  parameter int IMG_H      = 195,
  parameter int ORIGIN_X   = 125,
  parameter int REST_Y     = 142,
  parameter int SLIDE_STEP = 4
`ifdef LOSE_OVERLAY_KEY_EN
  , parameter logic [23:0] KEY_RGB = 24'hffffff
`endif
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        show,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [23:0] bg_rgb,
  output logic [16:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [23:0] pix_rgb,
  output logic        at_rest
);

  localparam logic signed [10:0] HIDE_Y  = 11'(-IMG_H);
  localparam logic signed [10:0] REST_S  = 11'(REST_Y);
  localparam logic signed [10:0] STEP_S  = 11'(SLIDE_STEP);
  localparam logic signed [11:0] IMG_H_S = 12'(IMG_H);
  localparam logic signed [10:0] IMG_W_S = 11'(IMG_W);
  localparam logic [10:0]        ORG_X   = 11'(ORIGIN_X);
  localparam logic [16:0]        IMG_W_A = 17'(IMG_W);

  typedef enum logic [1:0] {HIDDEN, SLIDE, HOLD} state_t;

  state_t             state_q;
  logic signed [10:0] cur_y_q;
  logic signed [10:0] cur_y_d;
  logic               at_rest_q;

  assign cur_y_d = cur_y_q + STEP_S;

  // Dropping show wins over a coincident frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= HIDDEN;
      cur_y_q   <= HIDE_Y;
      at_rest_q <= 1'b0;
    end else if (!show) begin
      state_q   <= HIDDEN;
      cur_y_q   <= HIDE_Y;
      at_rest_q <= 1'b0;
    end else if (frame_start) begin
      case (state_q)
        HIDDEN: state_q <= SLIDE;
        SLIDE: begin
          if (cur_y_d >= REST_S) begin
            cur_y_q   <= REST_S;
            state_q   <= HOLD;
            at_rest_q <= 1'b1;
          end else begin
            cur_y_q <= cur_y_d;
          end
        end
        default: ;
      endcase
    end
  end

  // One extra bit on row keeps large DrawY minus a negative cur_y from wrapping.
  logic signed [11:0] row_s;
  logic signed [10:0] col_s;
  logic               in_win;

  assign row_s  = $signed({2'b00, DrawY}) - $signed({cur_y_q[10], cur_y_q});
  assign col_s  = $signed({1'b0, DrawX} - ORG_X);
  assign in_win = (state_q != HIDDEN) && !row_s[11] && (row_s < IMG_H_S)
                  && !col_s[10] && (col_s < IMG_W_S);

  assign rom_addr = in_win ? ({6'b0, row_s[10:0]} * IMG_W_A + {7'b0, col_s[9:0]}) : 17'd0;

  logic        in_win_q;
  logic [23:0] bg_q;
  logic [23:0] pix_q;
  logic [23:0] pix_d;

  always_comb begin
    pix_d = bg_q;
`ifdef LOSE_OVERLAY_KEY_EN
    if (in_win_q && (rom_data != KEY_RGB)) pix_d = rom_data;
`else
    if (in_win_q) pix_d = rom_data;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_win_q <= 1'b0;
      bg_q     <= 24'd0;
      pix_q    <= 24'd0;
    end else begin
      in_win_q <= in_win;
      bg_q     <= bg_rgb;
      pix_q    <= pix_d;
    end
  end

  assign pix_rgb = pix_q;
  assign at_rest = at_rest_q;

endmodule

// File: tb/tb_lose_overlay_compositor.sv
// Scoreboard bench for lose_overlay_compositor: directed pixels and frame pulses, queued expectations.
// Keying expectations follow LOSE_OVERLAY_KEY_EN.
module tb_lose_overlay_compositor;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        show;
  logic        frame_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [23:0] bg_rgb;
  logic [16:0] rom_addr;
  logic [23:0] rom_data;
  logic [23:0] pix_rgb;
  logic        at_rest;

  lose_overlay_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .show(show), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .bg_rgb(bg_rgb), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_rgb(pix_rgb), .at_rest(at_rest)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        rom_force = 1'b0;
  logic [23:0] rom_force_val = 24'd0;

  function automatic logic [23:0] rom_f(input logic [16:0] a);
    return {a, 7'h2b};
  endfunction

  always @(posedge Clk) begin
    cyc++;
    rom_data <= rom_force ? rom_force_val : rom_f(rom_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard
  int          due_q[$];
  logic [23:0] exp_q[$];

  always @(negedge Clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      if (due_q[0] < cyc) chk("pix_missed", 32'd1, 32'd0);
      else chk("pix_rgb", {8'd0, pix_rgb}, {8'd0, exp_q[0]});
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
  end

  // spec-level model: 0 HIDDEN, 1 SLIDE, 2 HOLD
  int state_m = 0;
  int cur_y_m = -195;

  task automatic drive_pix(input int x, input int y, input logic [23:0] bg,
                           input logic force_en = 1'b0, input logic [23:0] force_val = 24'd0);
    int row, col, addr;
    bit win;
    logic [23:0] rv, e;
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y); bg_rgb = bg;
    rom_force = force_en; rom_force_val = force_val;
    #1;
    row = y - cur_y_m;
    col = x - 125;
    win = (state_m != 0) && row >= 0 && row < 195 && col >= 0 && col < 390;
    addr = win ? row * 390 + col : 0;
    chk($sformatf("rom_addr(%0d,%0d)", x, y), {15'd0, rom_addr}, 32'(addr));
    rv = force_en ? force_val : rom_f(17'(addr));
    e = win ? rv : bg;
`ifdef LOSE_OVERLAY_KEY_EN
    if (win && rv == 24'hffffff) e = bg;
`endif
    due_q.push_back(cyc + 2);
    exp_q.push_back(e);
  endtask

  task automatic pulse();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    if (show) begin
      if (state_m == 0) state_m = 1;
      else if (state_m == 1) begin
        cur_y_m += 4;
        if (cur_y_m >= 142) begin cur_y_m = 142; state_m = 2; end
      end
    end
    chk("at_rest_after_pulse", {31'd0, at_rest}, {31'd0, state_m == 2});
  endtask

  task automatic probe_y();
    drive_pix(125, (cur_y_m < 0) ? 0 : cur_y_m, 24'h0a0b0c);
  endtask

  task automatic drop_show();
    @(negedge Clk);
    show = 1'b0;
    @(negedge Clk);
    state_m = 0; cur_y_m = -195;
    chk("at_rest_after_drop", {31'd0, at_rest}, 32'd0);
  endtask

  task automatic flush();
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    Reset_n = 1'b0; show = 1'b0; frame_start = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; bg_rgb = 24'd0;
    #2;
    chk("reset_pix", {8'd0, pix_rgb}, 32'd0);
    chk("reset_at_rest", {31'd0, at_rest}, 32'd0);
    chk("reset_rom_addr", {15'd0, rom_addr}, 32'd0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // hidden: background passes through with two cycles of latency
    for (int i = 0; i < 8; i++)
      drive_pix($urandom_range(639, 0), $urandom_range(479, 0), 24'($urandom));
    drive_pix(125, 142, 24'h445566);
    chk("hidden_at_rest", {31'd0, at_rest}, 32'd0);

    // slide to rest, probing cur_y after every pulse
    show = 1'b1;
    for (int i = 0; i < 86; i++) begin
      pulse();
      probe_y();
    end
    chk("at_rest_hold", {31'd0, at_rest}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      pulse();
      drive_pix(125, 143, 24'h0);
      drive_pix(125, 141, 24'h777777);
    end

    // rest-position corners
    drive_pix(125, 142, 24'h010203);
    drive_pix(514, 336, 24'h040506);
    drive_pix(515, 336, 24'h070809);
    drive_pix(125, 337, 24'h0a0b0c);
    drive_pix(124, 200, 24'h0d0e0f);

    // key colour and a near-key colour
    drive_pix(300, 250, 24'h123456, 1'b1, 24'hffffff);
    drive_pix(300, 250, 24'h123456, 1'b1, 24'h262828);
    drive_pix(300, 250, 24'h654321, 1'b0);
    flush();

    // mid-slide at cur_y = -155
    drop_show();
    show = 1'b1;
    for (int i = 0; i < 11; i++) pulse();
    drive_pix(125, 0, 24'h111111);
    drive_pix(125, 40, 24'h222222);
    drive_pix(514, 0, 24'h333333);

    // show drops together with frame_start during SLIDE
    @(negedge Clk);
    show = 1'b0; frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    state_m = 0; cur_y_m = -195;
    chk("drop_fs_at_rest", {31'd0, at_rest}, 32'd0);
    drive_pix(125, 0, 24'h444444);
    show = 1'b1;
    pulse();
    pulse();
    drive_pix(125, 0, 24'h555555);
    flush();

    // asynchronous reset mid-slide
    for (int i = 0; i < 3; i++) pulse();
    flush();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_pix", {8'd0, pix_rgb}, 32'd0);
    chk("async_rst_at_rest", {31'd0, at_rest}, 32'd0);
    chk("async_rst_rom_addr", {15'd0, rom_addr}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    state_m = 0; cur_y_m = -195;
    repeat (3) drive_pix(125, 0, 24'h666666);
    pulse();
    pulse();
    drive_pix(125, 0, 24'h777777);

    repeat (4) @(negedge Clk);
    chk("scoreboard_drained", 32'(due_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
